// File: rtl/tabby_evt_pkg.sv
// Shared definitions for the tabby event controller: register map,
// version word and read-FSM states.
package tabby_evt_pkg;

  localparam int unsigned REG_RAW     = 0;
  localparam int unsigned REG_PEND    = 1;
  localparam int unsigned REG_MASK    = 2;
  localparam int unsigned REG_IRQ     = 3;
  localparam int unsigned REG_MODE    = 4;
  localparam int unsigned REG_FORCE   = 5;
  localparam int unsigned REG_SCRATCH = 6;
  localparam int unsigned REG_VERSION = 7;

  localparam logic [31:0] VERSION = 32'h0001_000A;

  typedef enum logic [1:0] {
    IDLE,
    RD1,
    RD2
  } rd_state_e;

  // Expands the four Avalon byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/tabby_evt_sync.sv
// Brings asynchronous event lines into q_clock through two flops and
// delays them once more so rising edges can be detected.
module tabby_evt_sync #(
  parameter int NUM_EVENTS = 10
) (
  input  logic                  q_clock,
  input  logic                  q_reset,
  input  logic [NUM_EVENTS-1:0] evt_i,
  output logic [NUM_EVENTS-1:0] raw_o,
  output logic [NUM_EVENTS-1:0] rise_o
);

  logic [NUM_EVENTS-1:0] meta_q;
  logic [NUM_EVENTS-1:0] sync_q;
  logic [NUM_EVENTS-1:0] dly_q;

  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      meta_q <= '0;
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      meta_q <= evt_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign raw_o  = sync_q;
  assign rise_o = sync_q & ~dly_q;

endmodule

// File: rtl/tabby_event_ctrl.sv
// Avalon-MM event/interrupt controller: latches synchronized events as
// pending bits, masks them into a registered irq vector, fixed-latency reads.
module tabby_event_ctrl
  import tabby_evt_pkg::*;
#(
  parameter int                    NUM_EVENTS = 10,
  parameter int                    ADDR_W     = 3,
  parameter logic [NUM_EVENTS-1:0] RESET_MASK = '0
) (
  input  logic                  q_clock,
  input  logic                  q_reset,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic [31:0]           avs_writedata,
  input  logic [3:0]            avs_byteenable,
  input  logic                  avs_write,
  input  logic                  avs_read,
  output logic [31:0]           avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  avs_waitrequest,
  input  logic [NUM_EVENTS-1:0] evt_in,
  output logic [NUM_EVENTS-1:0] irq_out,
  output logic                  irq_any
);

  rd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [NUM_EVENTS-1:0] pend_q, pend_d;
  logic [NUM_EVENTS-1:0] mask_q, mask_d;
  logic [NUM_EVENTS-1:0] mode_q, mode_d;
  logic [31:0]           scratch_q, scratch_d;
  logic [NUM_EVENTS-1:0] irq_q;
  logic                  irq_any_q;

  logic [NUM_EVENTS-1:0] raw, rise, hw_set, clr, frc;
  logic [31:0]           bm, wmask, wr_addr, rd_addr;
  logic                  rd_acc, wr_acc;

  tabby_evt_sync #(.NUM_EVENTS(NUM_EVENTS)) u_sync (
    .q_clock (q_clock),
    .q_reset (q_reset),
    .evt_i   (evt_in),
    .raw_o   (raw),
    .rise_o  (rise)
  );

  // A simultaneous read and write lets the read go first; the write sees
  // waitrequest during RD1 and lands afterwards.
  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    mask_d    = mask_q;
    mode_d    = mode_q;
    scratch_d = scratch_q;
    clr       = '0;
    frc       = '0;

    avs_waitrequest = (state_q == RD1);
    rd_acc  = avs_read & ~avs_waitrequest;
    wr_acc  = avs_write & ~avs_waitrequest & ~avs_read;
    bm      = byte_mask(avs_byteenable);
    wmask   = avs_writedata & bm;
    wr_addr = 32'(avs_address);
    rd_addr = 32'(raddr_q);

    if (rd_acc) raddr_d = avs_address;

    case (state_q)
      IDLE: if (rd_acc) state_d = RD1;
      RD1: begin
        state_d  = RD2;
        rvalid_d = 1'b1;
        case (rd_addr)
          REG_RAW:     rdata_d = 32'(raw);
          REG_PEND:    rdata_d = 32'(pend_q);
          REG_MASK:    rdata_d = 32'(mask_q);
          REG_IRQ:     rdata_d = 32'(pend_q & mask_q);
          REG_MODE:    rdata_d = 32'(mode_q);
          REG_SCRATCH: rdata_d = scratch_q;
          REG_VERSION: rdata_d = {VERSION[31:8], 8'(NUM_EVENTS)};
          default:     rdata_d = '0;
        endcase
      end
      RD2:     state_d = rd_acc ? RD1 : IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_acc) begin
      case (wr_addr)
        REG_PEND:    clr       = wmask[NUM_EVENTS-1:0];
        REG_MASK:    mask_d    = (mask_q & ~bm[NUM_EVENTS-1:0]) | wmask[NUM_EVENTS-1:0];
        REG_MODE:    mode_d    = (mode_q & ~bm[NUM_EVENTS-1:0]) | wmask[NUM_EVENTS-1:0];
        REG_FORCE:   frc       = wmask[NUM_EVENTS-1:0];
        REG_SCRATCH: scratch_d = (scratch_q & ~bm) | wmask;
        default:     ;
      endcase
    end

    // Hardware set is OR-ed after the clear so it wins a same-cycle W1C.
    hw_set = (rise & ~mode_q) | (raw & mode_q);
    pend_d = (pend_q & ~clr) | hw_set | frc;
  end

  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      state_q   <= IDLE;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      pend_q    <= '0;
      mask_q    <= RESET_MASK;
      mode_q    <= '0;
      scratch_q <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      scratch_q <= scratch_d;
      irq_q     <= pend_d & mask_d;
      irq_any_q <= |(pend_d & mask_d);
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq_out           = irq_q;
  assign irq_any           = irq_any_q;

endmodule

// File: tb/tb_tabby_event_ctrl.sv
// Self-checking bench for tabby_event_ctrl: register vector table, read
// scoreboard, and hand sequences for event, W1C and reset corner cases.
module tb_tabby_event_ctrl;

  localparam int NE = 10;
  localparam logic [2:0] A_RAW     = 3'd0;
  localparam logic [2:0] A_PEND    = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_IRQ     = 3'd3;
  localparam logic [2:0] A_MODE    = 3'd4;
  localparam logic [2:0] A_FORCE   = 3'd5;
  localparam logic [2:0] A_SCRATCH = 3'd6;
  localparam logic [2:0] A_VERSION = 3'd7;

  logic          q_clock = 1'b0;
  logic          q_reset;
  logic [2:0]    avs_address;
  logic [31:0]   avs_writedata;
  logic [3:0]    avs_byteenable;
  logic          avs_write;
  logic          avs_read;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic          avs_waitrequest;
  logic [NE-1:0] evt_in;
  logic [NE-1:0] irq_out;
  logic          irq_any;

  int total = 0;
  int bad = 0;
  int negCount = 0;

  typedef struct {
    logic [31:0] data;
    int          acceptNeg;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit            isWrite;
    logic [2:0]    addr;
    logic [31:0]   data;
    logic [3:0]    be;
    logic [31:0]   expData;
    logic [NE-1:0] expIrq;
    string         name;
  } vec_t;
  vec_t vecs[$];

  always #4 q_clock = ~q_clock;

  tabby_event_ctrl #(.NUM_EVENTS(NE), .ADDR_W(3), .RESET_MASK('0)) dut (
    .q_clock           (q_clock),
    .q_reset           (q_reset),
    .avs_address       (avs_address),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_write         (avs_write),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .evt_in            (evt_in),
    .irq_out           (irq_out),
    .irq_any           (irq_any)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Read results are popped here; latency is counted in negedges from accept.
  always @(negedge q_clock) begin : monitor
    exp_t e;
    negCount++;
    if (avs_readdatavalid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid: got readdatavalid=1 expected 0");
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_data"}, avs_readdata, e.data);
        checkOutput({e.name, "_lat"}, 32'(negCount - e.acceptNeg), 32'd2);
      end
    end
  end

  task automatic waitAccept(output bit ok);
    logic w;
    int n;
    n = 0;
    do begin
      @(negedge q_clock);
      w = avs_waitrequest;
      @(posedge q_clock);
      n++;
    end while (w !== 1'b0 && n < 10);
    ok = (w === 1'b0);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge q_clock);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL read_timeout: got %0d pending reads expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    bit ok;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    waitAccept(ok);
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL write_timeout: got waitrequest=1 expected 0");
    end
    #1 avs_write = 1'b0;
  endtask

  task automatic busRead(input logic [2:0] a, input logic [31:0] expd, input string name);
    bit ok;
    avs_address = a; avs_read = 1'b1;
    waitAccept(ok);
    if (ok) sb.push_back('{expd, negCount, name});
    else begin
      total++;
      bad++;
      $display("[TB] FAIL %s_accept: got waitrequest=1 expected 0", name);
    end
    #1 avs_read = 1'b0;
    waitDrain();
  endtask

  task automatic applyStimulus();
    foreach (vecs[i]) begin
      if (vecs[i].isWrite) begin
        busWrite(vecs[i].addr, vecs[i].data, vecs[i].be);
        checkOutput({vecs[i].name, "_irq"}, 32'(irq_out), 32'(vecs[i].expIrq));
      end else begin
        busRead(vecs[i].addr, vecs[i].expData, vecs[i].name);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    bit seen;
    q_reset = 1'b1;
    avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
    avs_write = 1'b0; avs_read = 1'b0; evt_in = '0;
    repeat (3) @(posedge q_clock);
    #1 q_reset = 1'b0;
    @(posedge q_clock);
    #1;

    checkOutput("rst_irq", 32'(irq_out), 32'd0);
    checkOutput("rst_any", 32'(irq_any), 32'd0);
    checkOutput("rst_valid", 32'(avs_readdatavalid), 32'd0);
    checkOutput("rst_wait", 32'(avs_waitrequest), 32'd0);
    checkOutput("rst_rdata", avs_readdata, 32'd0);
    busRead(A_VERSION, 32'h0001_000A, "version");
    busRead(A_MASK, 32'h0, "rst_mask");

    vecs.push_back('{1, A_SCRATCH, 32'hFFFF_FFFF, 4'hF, 32'h0, '0, "wr_scratch"});
    vecs.push_back('{1, A_SCRATCH, 32'h0000_0000, 4'h2, 32'h0, '0, "wr_scratch_be"});
    vecs.push_back('{0, A_SCRATCH, 32'h0, 4'h0, 32'hFFFF_00FF, '0, "scratch_be"});
    vecs.push_back('{1, A_MASK, 32'hFFFF_FFFF, 4'hF, 32'h0, '0, "wr_mask"});
    vecs.push_back('{0, A_MASK, 32'h0, 4'h0, 32'h0000_03FF, '0, "mask_width"});
    vecs.push_back('{1, A_MASK, 32'h0, 4'h1, 32'h0, '0, "wr_mask_be"});
    vecs.push_back('{0, A_MASK, 32'h0, 4'h0, 32'h0000_0300, '0, "mask_be"});
    vecs.push_back('{1, A_MASK, 32'h0, 4'hF, 32'h0, '0, "wr_mask0"});
    vecs.push_back('{1, A_MODE, 32'h0000_00A5, 4'hF, 32'h0, '0, "wr_mode"});
    vecs.push_back('{0, A_MODE, 32'h0, 4'h0, 32'h0000_00A5, '0, "mode_rw"});
    vecs.push_back('{1, A_MODE, 32'h0, 4'h1, 32'h0, '0, "wr_mode_be"});
    vecs.push_back('{0, A_MODE, 32'h0, 4'h0, 32'h0, '0, "mode_be"});
    vecs.push_back('{1, A_RAW, 32'hFFFF_FFFF, 4'hF, 32'h0, '0, "wr_raw"});
    vecs.push_back('{1, A_VERSION, 32'h0, 4'hF, 32'h0, '0, "wr_version"});
    vecs.push_back('{0, A_VERSION, 32'h0, 4'h0, 32'h0001_000A, '0, "version_ro"});
    vecs.push_back('{0, A_RAW, 32'h0, 4'h0, 32'h0, '0, "raw_idle"});
    vecs.push_back('{1, A_FORCE, 32'h0000_0201, 4'hF, 32'h0, '0, "wr_force"});
    vecs.push_back('{0, A_PEND, 32'h0, 4'h0, 32'h0000_0201, '0, "force_pend"});
    vecs.push_back('{0, A_IRQ, 32'h0, 4'h0, 32'h0, '0, "irq_masked"});
    vecs.push_back('{0, A_FORCE, 32'h0, 4'h0, 32'h0, '0, "force_rd0"});
    vecs.push_back('{1, A_PEND, 32'h0000_0201, 4'h2, 32'h0, '0, "wr_w1c_be"});
    vecs.push_back('{0, A_PEND, 32'h0, 4'h0, 32'h0000_0001, '0, "w1c_be"});
    vecs.push_back('{1, A_PEND, 32'h0000_0201, 4'hF, 32'h0, '0, "wr_w1c_all"});
    vecs.push_back('{0, A_PEND, 32'h0, 4'h0, 32'h0, '0, "w1c_all"});
    applyStimulus();

    // Edge mode: a 4-cycle pulse on bit 3 must raise irq within 5 cycles.
    busWrite(A_MASK, 32'h0000_03FF, 4'hF);
    evt_in[3] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge q_clock);
      #1;
      if (irq_out[3] === 1'b1) seen = 1'b1;
    end
    checkOutput("edge_irq_seen", 32'(seen), 32'd1);
    checkOutput("edge_irq_any", 32'(irq_any), 32'd1);
    @(posedge q_clock);
    #1 evt_in[3] = 1'b0;
    busRead(A_PEND, 32'h0000_0008, "edge_pend");
    busRead(A_IRQ, 32'h0000_0008, "edge_irqreg");
    busWrite(A_PEND, 32'h0000_0008, 4'hF);
    checkOutput("edge_clr_irq", 32'(irq_out), 32'd0);
    checkOutput("edge_clr_any", 32'(irq_any), 32'd0);

    // Level mode: W1C is ineffective while the line stays high.
    busWrite(A_MODE, 32'h0000_0020, 4'hF);
    evt_in[5] = 1'b1;
    repeat (4) @(posedge q_clock);
    #1;
    busWrite(A_PEND, 32'h0000_0020, 4'hF);
    busRead(A_PEND, 32'h0000_0020, "level_hold");
    checkOutput("level_any", 32'(irq_any), 32'd1);
    evt_in[5] = 1'b0;
    repeat (4) @(posedge q_clock);
    #1;
    busWrite(A_PEND, 32'h0000_0020, 4'hF);
    busRead(A_PEND, 32'h0, "level_clr");
    checkOutput("level_clr_any", 32'(irq_any), 32'd0);
    busWrite(A_MODE, 32'h0, 4'hF);

    // W1C accepted on the very edge where the synchronized rise sets PEND[3].
    evt_in[3] = 1'b1;
    repeat (2) @(posedge q_clock);
    #1;
    busWrite(A_PEND, 32'h0000_0008, 4'hF);
    busRead(A_PEND, 32'h0000_0008, "set_wins");
    evt_in[3] = 1'b0;
    busWrite(A_PEND, 32'h0000_0008, 4'hF);
    busRead(A_PEND, 32'h0, "set_wins_clr");

    // Read and write together: read first, write held off by waitrequest.
    avs_address = A_SCRATCH; avs_writedata = 32'h1234_5678; avs_byteenable = 4'hF;
    avs_read = 1'b1; avs_write = 1'b1;
    waitAccept(ok);
    if (ok) sb.push_back('{32'hFFFF_00FF, negCount, "rw_prio"});
    #1 avs_read = 1'b0;
    checkOutput("rw_accept", 32'(ok), 32'd1);
    checkOutput("rw_wait", 32'(avs_waitrequest), 32'd1);
    waitAccept(ok);
    checkOutput("rw_wr_accept", 32'(ok), 32'd1);
    #1 avs_write = 1'b0;
    waitDrain();
    busRead(A_SCRATCH, 32'h1234_5678, "rw_late_wr");

    // Reset during RD1: the read is dropped and all outputs clear.
    busWrite(A_FORCE, 32'h0000_0001, 4'hF);
    checkOutput("force_irq", 32'(irq_out), 32'h0000_0001);
    avs_address = A_VERSION; avs_read = 1'b1;
    waitAccept(ok);
    #1 avs_read = 1'b0;
    q_reset = 1'b1;
    #1;
    checkOutput("mid_rst_rdata", avs_readdata, 32'd0);
    checkOutput("mid_rst_irq", 32'(irq_out), 32'd0);
    checkOutput("mid_rst_any", 32'(irq_any), 32'd0);
    checkOutput("mid_rst_wait", 32'(avs_waitrequest), 32'd0);
    checkOutput("mid_rst_valid", 32'(avs_readdatavalid), 32'd0);
    repeat (2) @(posedge q_clock);
    #1 q_reset = 1'b0;
    repeat (4) @(posedge q_clock);
    #1;
    busRead(A_MASK, 32'h0, "post_rst_mask");
    busRead(A_PEND, 32'h0, "post_rst_pend");
    busRead(A_VERSION, 32'h0001_000A, "post_rst_ver");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
